// File: rtl/axilite_gpio_in_if.sv
// AXI4-Lite bundle for the GPIO input block.
// slave modport : responder side (axilite_gpio_in).
// master modport: requester side (crossbar / testbench).
// Signal names keep the s_axilite_ prefix used at the SoC level.
interface axilite_gpio_in_if;
  logic [31:0] s_axilite_awaddr;
  logic        s_axilite_awvalid;
  logic        s_axilite_awready;
  logic [31:0] s_axilite_wdata;
  logic [3:0]  s_axilite_wstrb;
  logic        s_axilite_wvalid;
  logic        s_axilite_wready;
  logic [1:0]  s_axilite_bresp;
  logic        s_axilite_bvalid;
  logic        s_axilite_bready;
  logic [31:0] s_axilite_araddr;
  logic        s_axilite_arvalid;
  logic        s_axilite_arready;
  logic [31:0] s_axilite_rdata;
  logic [1:0]  s_axilite_rresp;
  logic        s_axilite_rvalid;
  logic        s_axilite_rready;

  modport slave (
    input  s_axilite_awaddr, s_axilite_awvalid,
    input  s_axilite_wdata, s_axilite_wstrb, s_axilite_wvalid,
    input  s_axilite_bready,
    input  s_axilite_araddr, s_axilite_arvalid,
    input  s_axilite_rready,
    output s_axilite_awready, s_axilite_wready,
    output s_axilite_bresp, s_axilite_bvalid,
    output s_axilite_arready,
    output s_axilite_rdata, s_axilite_rresp, s_axilite_rvalid
  );

  modport master (
    output s_axilite_awaddr, s_axilite_awvalid,
    output s_axilite_wdata, s_axilite_wstrb, s_axilite_wvalid,
    output s_axilite_bready,
    output s_axilite_araddr, s_axilite_arvalid,
    output s_axilite_rready,
    input  s_axilite_awready, s_axilite_wready,
    input  s_axilite_bresp, s_axilite_bvalid,
    input  s_axilite_arready,
    input  s_axilite_rdata, s_axilite_rresp, s_axilite_rvalid
  );
endinterface

// File: rtl/axilite_gpio_in.sv
// AXI4-Lite GPIO input block with edge-triggered interrupts.
//
// gpio_in_lane   : per-pin 2-flop synchronizer, optional debounce filter,
//                  edge detector qualified by the pin's EDGE_SEL bit.
// axilite_gpio_in: register file + independent write/read AXI4-Lite FSMs.
//   clock_i   : single clock domain
//   reset_ni  : synchronous active-low reset
//   gpio_i    : asynchronous external pins [NUM_IN-1:0]
//   irq_o     : registered |(IRQ_STATUS & IRQ_EN)
//   s_axilite : AXI4-Lite slave modport (axilite_gpio_in_if)
// Register map (addr[11:0]): 0x0 DATA RO, 0x4 IRQ_EN RW, 0x8 IRQ_STATUS W1C,
//   0xC EDGE_SEL RW (1=rising, 0=falling). Unaligned or >0xC -> SLVERR.
// Build option: define GPIO_IN_DEBOUNCE_EN to put a DEBOUNCE_CYCLES stable-count
//   filter behind each synchronizer; otherwise the filter is a wire.

module gpio_in_lane
`ifdef GPIO_IN_DEBOUNCE_EN
  #(parameter int unsigned DEBOUNCE_CYCLES = 16)
`endif
  (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic edge_sel,
  output logic filt,
  output logic hit
);
  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], pin};
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // Counts consecutive cycles the synchronized pin disagrees with the
  // filtered value; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[1] == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      filt_q <= sync_q[1];
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
  assign filt = filt_q;
`else
  assign filt = sync_q[1];
`endif

  // prev_q resets to 0, so the reset baseline is "low".
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= filt;
  end

  assign hit = edge_sel ? (filt & ~prev_q) : (~filt & prev_q);
endmodule

module axilite_gpio_in #(
  parameter int unsigned NUM_IN          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic [NUM_IN-1:0] gpio_i,
  output logic              irq_o,
  axilite_gpio_in_if.slave  s_axilite
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic       err;
    logic [1:0] idx;   // 0 DATA, 1 IRQ_EN, 2 IRQ_STATUS, 3 EDGE_SEL
  } dec_t;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  function automatic dec_t decode(input logic [11:0] a);
    dec_t d;
    d.err = (a[1:0] != 2'b00) || (a > 12'hC);
    d.idx = a[3:2];
    return d;
  endfunction

  logic [NUM_IN-1:0] filt_v, hit_v;
  logic [NUM_IN-1:0] en_q, st_q, es_q;
  logic              irq_q;

  // ---------------------------------------------------------------- lanes
  if (NUM_IN >= 1 && NUM_IN <= 32 && DEBOUNCE_CYCLES >= 2) begin : g_lanes
    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
      gpio_in_lane
`ifdef GPIO_IN_DEBOUNCE_EN
        #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
        u_lane (
          .clk      (clock_i),
          .rst_n    (reset_ni),
          .pin      (gpio_i[i]),
          .edge_sel (es_q[i]),
          .filt     (filt_v[i]),
          .hit      (hit_v[i])
        );
    end
  end else begin : g_no_lanes
    // Out-of-range configuration: inputs stay inert instead of building
    // a malformed filter.
    assign filt_v = '0;
    assign hit_v  = '0;
  end

  // ---------------------------------------------------------- write path
  wstate_t    wstate;
  logic       bvalid_q;
  logic [1:0] bresp_q;
  logic       wr_go;
  dec_t       wdec;
  logic [31:0]       wmask32;
  logic [NUM_IN-1:0] wm, wd, clr;
  logic we_en, we_st, we_es;

  assign wdec  = decode(s_axilite.s_axilite_awaddr[11:0]);
  // Address and data are only taken together; reset forces ready low.
  assign wr_go = reset_ni && (wstate == W_IDLE)
              && s_axilite.s_axilite_awvalid && s_axilite.s_axilite_wvalid;

  assign s_axilite.s_axilite_awready = wr_go;
  assign s_axilite.s_axilite_wready  = wr_go;
  assign s_axilite.s_axilite_bvalid  = bvalid_q;
  assign s_axilite.s_axilite_bresp   = bresp_q;

  assign wmask32 = {{8{s_axilite.s_axilite_wstrb[3]}}, {8{s_axilite.s_axilite_wstrb[2]}},
                    {8{s_axilite.s_axilite_wstrb[1]}}, {8{s_axilite.s_axilite_wstrb[0]}}};
  assign wm = wmask32[NUM_IN-1:0];
  assign wd = s_axilite.s_axilite_wdata[NUM_IN-1:0];

  assign we_en = wr_go && !wdec.err && (wdec.idx == 2'd1);
  assign we_st = wr_go && !wdec.err && (wdec.idx == 2'd2);
  assign we_es = wr_go && !wdec.err && (wdec.idx == 2'd3);
  assign clr   = we_st ? (wd & wm) : '0;

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      wstate   <= W_IDLE;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (wstate)
        W_IDLE: if (wr_go) begin
          bresp_q  <= wdec.err ? RESP_SLVERR : RESP_OKAY;
          bvalid_q <= 1'b1;
          wstate   <= W_RESP;
        end
        W_RESP: if (s_axilite.s_axilite_bready) begin
          bvalid_q <= 1'b0;
          wstate   <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      en_q  <= '0;
      st_q  <= '0;
      es_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      if (we_en) en_q <= (en_q & ~wm) | (wd & wm);
      if (we_es) es_q <= (es_q & ~wm) | (wd & wm);
      // Clear first, then OR in new edges: a coincident edge wins.
      st_q  <= (st_q & ~clr) | hit_v;
      irq_q <= |(st_q & en_q);
    end
  end

  assign irq_o = irq_q;

  // ----------------------------------------------------------- read path
  rstate_t     rstate;
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q, rword;
  logic        rd_go;
  dec_t        rdec;

  assign rdec  = decode(s_axilite.s_axilite_araddr[11:0]);
  assign s_axilite.s_axilite_arready = reset_ni && (rstate == R_IDLE);
  assign rd_go = s_axilite.s_axilite_arready && s_axilite.s_axilite_arvalid;

  assign s_axilite.s_axilite_rvalid = rvalid_q;
  assign s_axilite.s_axilite_rresp  = rresp_q;
  assign s_axilite.s_axilite_rdata  = rdata_q;

  always_comb begin
    rword = '0;
    if (!rdec.err) begin
      case (rdec.idx)
        2'd0: rword = 32'(filt_v);
        2'd1: rword = 32'(en_q);
        2'd2: rword = 32'(st_q);
        2'd3: rword = 32'(es_q);
        default: rword = '0;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      rstate   <= R_IDLE;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (rd_go) begin
          rdata_q  <= rword;
          rresp_q  <= rdec.err ? RESP_SLVERR : RESP_OKAY;
          rvalid_q <= 1'b1;
          rstate   <= R_DATA;
        end
        R_DATA: if (s_axilite.s_axilite_rready) begin
          rvalid_q <= 1'b0;
          rstate   <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Upper address bits alias the 4 KiB window; lanes above NUM_IN are dropped.
  logic unused_bits;
  assign unused_bits = ^{s_axilite.s_axilite_awaddr[31:12], s_axilite.s_axilite_araddr[31:12],
                         s_axilite.s_axilite_wdata, wmask32};
endmodule
